// File: rtl/mem_rd_req_gen_pkg.sv
// Shared definitions for the read-request generator.
// Holds the FSM encoding and the ROM entry field layout {type, base, offset, size, loop_max}.
package mem_rd_req_gen_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_REQ   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Field LSB positions inside a ROM entry; loop_max sits at bit 0.
  localparam int LOOP_LSB = 0;

  function automatic int size_lsb(input int loop_w);
    return loop_w;
  endfunction

  function automatic int offset_lsb(input int loop_w, input int size_w);
    return loop_w + size_w;
  endfunction

  function automatic int base_lsb(input int loop_w, input int size_w, input int off_w);
    return loop_w + size_w + off_w;
  endfunction

  function automatic int type_lsb(input int loop_w, input int size_w, input int off_w,
                                  input int base_w);
    return loop_w + size_w + off_w + base_w;
  endfunction

endpackage

// File: rtl/mem_rd_req_gen_if.sv
// Config-ROM port and downstream read-request channel of the request generator.
interface mem_rd_req_gen_if #(
  parameter int ADDR_W        = 32,
  parameter int TX_SIZE_WIDTH = 20,
  parameter int D_TYPE_W      = 2,
  parameter int ROM_ADDR_W    = 6,
  parameter int ROM_WIDTH     = 80
);
  logic [ROM_ADDR_W-1:0]    rom_addr;
  logic [ROM_WIDTH-1:0]     rom_data;
  logic                     rd_ready;
  logic                     rd_req;
  logic [ADDR_W-1:0]        rd_addr;
  logic [TX_SIZE_WIDTH-1:0] rd_req_size;
  logic [D_TYPE_W-1:0]      rd_type;

  modport master (
    output rom_addr,
    input  rom_data,
    input  rd_ready,
    output rd_req,
    output rd_addr,
    output rd_req_size,
    output rd_type
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    output rd_ready,
    input  rd_req,
    input  rd_addr,
    input  rd_req_size,
    input  rd_type
  );
endinterface

// File: rtl/mem_rd_req_gen_stepper.sv
// Per-entry loop counter and address-offset accumulator for the request generator.
module mem_rd_addr_stepper #(
  parameter int ADDR_W        = 32,
  parameter int OFFSET_ADDR_W = 16,
  parameter int RD_LOOP_W     = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     step,
  input  logic [OFFSET_ADDR_W-1:0] offset,
  output logic [RD_LOOP_W-1:0]     count,
  output logic [ADDR_W-1:0]        addr_offset
);
  logic [RD_LOOP_W-1:0] r_count;
  logic [ADDR_W-1:0]    r_acc;

  // Clear wins over step; the accumulator wraps modulo 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
      r_acc   <= '0;
    end else if (clear) begin
      r_count <= '0;
      r_acc   <= '0;
    end else if (step) begin
      r_count <= r_count + RD_LOOP_W'(1);
      r_acc   <= r_acc + ADDR_W'(offset);
    end
  end

  assign count       = r_count;
  assign addr_offset = r_acc;
endmodule

// File: rtl/mem_rd_req_gen.sv
// Walks config ROM entries 0..cfg_last_idx and issues loop_max+1 strided read
// requests per entry on the downstream channel.
module mem_rd_req_gen
  import mem_rd_req_gen_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int BASE_ADDR_W   = 32,
  parameter int OFFSET_ADDR_W = 16,
  parameter int TX_SIZE_WIDTH = 20,
  parameter int RD_LOOP_W     = 10,
  parameter int D_TYPE_W      = 2,
  parameter int ROM_ADDR_W    = 6,
  localparam int ROM_WIDTH    = D_TYPE_W + BASE_ADDR_W + OFFSET_ADDR_W + TX_SIZE_WIDTH + RD_LOOP_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ROM_ADDR_W-1:0] cfg_last_idx,
  mem_rd_req_gen_if.master      bus,
  output logic                  busy,
  output logic                  done
);
  localparam int SIZE_LSB = size_lsb(RD_LOOP_W);
  localparam int OFF_LSB  = offset_lsb(RD_LOOP_W, TX_SIZE_WIDTH);
  localparam int BASE_LSB = base_lsb(RD_LOOP_W, TX_SIZE_WIDTH, OFFSET_ADDR_W);
  localparam int TYPE_LSB = type_lsb(RD_LOOP_W, TX_SIZE_WIDTH, OFFSET_ADDR_W, BASE_ADDR_W);

  state_t                   r_state;
  state_t                   w_next_state;
  logic [ROM_ADDR_W-1:0]    r_idx;
  logic [ROM_ADDR_W-1:0]    r_last_idx;
  logic [D_TYPE_W-1:0]      r_type;
  logic [BASE_ADDR_W-1:0]   r_base;
  logic [OFFSET_ADDR_W-1:0] r_offset;
  logic [TX_SIZE_WIDTH-1:0] r_size;
  logic [RD_LOOP_W-1:0]     r_loop_max;

  logic                     w_clear;
  logic                     w_step;
  logic                     w_advance;
  logic [RD_LOOP_W-1:0]     w_count;
  logic [ADDR_W-1:0]        w_acc;

  mem_rd_addr_stepper #(
    .ADDR_W        (ADDR_W),
    .OFFSET_ADDR_W (OFFSET_ADDR_W),
    .RD_LOOP_W     (RD_LOOP_W)
  ) u_stepper (
    .clk         (clk),
    .reset       (reset),
    .clear       (w_clear),
    .step        (w_step),
    .offset      (r_offset),
    .count       (w_count),
    .addr_offset (w_acc)
  );

  always_comb begin
    w_next_state    = r_state;
    w_clear         = 1'b0;
    w_step          = 1'b0;
    w_advance       = 1'b0;
    busy            = (r_state != S_IDLE);
    done            = 1'b0;
    bus.rom_addr    = r_idx;
    bus.rd_req      = 1'b0;
    bus.rd_addr     = '0;
    bus.rd_req_size = '0;
    bus.rd_type     = '0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_FETCH;
          w_clear      = 1'b1;
        end
      end
      S_FETCH: w_next_state = S_LOAD;
      S_LOAD:  w_next_state = S_REQ;
      S_REQ: begin
        bus.rd_req      = bus.rd_ready;
        bus.rd_addr     = ADDR_W'(r_base) + w_acc;
        bus.rd_req_size = r_size;
        bus.rd_type     = r_type;
        // Each accepted request either steps within the entry or ends it.
        if (bus.rd_ready) begin
          if (w_count < r_loop_max) begin
            w_step = 1'b1;
          end else begin
            w_clear      = 1'b1;
            w_advance    = 1'b1;
            w_next_state = (r_idx == r_last_idx) ? S_DONE : S_FETCH;
          end
        end
      end
      S_DONE: begin
        done         = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_last_idx <= '0;
      r_type     <= '0;
      r_base     <= '0;
      r_offset   <= '0;
      r_size     <= '0;
      r_loop_max <= '0;
    end else begin
      r_state <= w_next_state;
      // The last index is captured once so mid-walk changes have no effect.
      if (r_state == S_IDLE && start) begin
        r_idx      <= '0;
        r_last_idx <= cfg_last_idx;
      end
      if (w_advance && r_idx != r_last_idx) begin
        r_idx <= r_idx + ROM_ADDR_W'(1);
      end
      if (r_state == S_LOAD) begin
        r_type     <= bus.rom_data[TYPE_LSB +: D_TYPE_W];
        r_base     <= bus.rom_data[BASE_LSB +: BASE_ADDR_W];
        r_offset   <= bus.rom_data[OFF_LSB +: OFFSET_ADDR_W];
        r_size     <= bus.rom_data[SIZE_LSB +: TX_SIZE_WIDTH];
        r_loop_max <= bus.rom_data[LOOP_LSB +: RD_LOOP_W];
      end
    end
  end
endmodule

// File: tb/tb_mem_rd_req_gen.sv
// Directed bench for mem_rd_req_gen: cycle-by-cycle vector table plus
// hand-written wrap, mid-walk reset and restart sequences.
module tb_mem_rd_req_gen;
  localparam int ADDR_W        = 32;
  localparam int BASE_ADDR_W   = 32;
  localparam int OFFSET_ADDR_W = 16;
  localparam int TX_SIZE_WIDTH = 20;
  localparam int RD_LOOP_W     = 10;
  localparam int D_TYPE_W      = 2;
  localparam int ROM_ADDR_W    = 6;
  localparam int ROM_WIDTH     = 80;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  start = 1'b0;
  logic [ROM_ADDR_W-1:0] cfg_last_idx = '0;
  logic                  busy;
  logic                  done;

  mem_rd_req_gen_if #(
    .ADDR_W(ADDR_W), .TX_SIZE_WIDTH(TX_SIZE_WIDTH), .D_TYPE_W(D_TYPE_W),
    .ROM_ADDR_W(ROM_ADDR_W), .ROM_WIDTH(ROM_WIDTH)
  ) bus ();

  mem_rd_req_gen #(
    .ADDR_W(ADDR_W), .BASE_ADDR_W(BASE_ADDR_W), .OFFSET_ADDR_W(OFFSET_ADDR_W),
    .TX_SIZE_WIDTH(TX_SIZE_WIDTH), .RD_LOOP_W(RD_LOOP_W), .D_TYPE_W(D_TYPE_W),
    .ROM_ADDR_W(ROM_ADDR_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .cfg_last_idx (cfg_last_idx),
    .bus          (bus),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Config ROM model with one cycle of read latency.
  logic [ROM_WIDTH-1:0] rom_mem [0:63];
  always @(posedge clk) bus.rom_data <= rom_mem[bus.rom_addr];

  typedef struct {
    logic        start;
    logic        rdy;
    logic [5:0]  cfg;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [19:0] exp_size;
    logic [1:0]  exp_type;
    logic        exp_busy;
    logic        exp_done;
    logic [5:0]  exp_rom_addr;
  } vec_t;

  vec_t        vecs [15];
  logic [31:0] addrs [16];
  int          n_vec = 0;
  int          n_bad = 0;

  function automatic logic [ROM_WIDTH-1:0] mk_entry(logic [1:0] t, logic [31:0] b,
                                                    logic [15:0] o, logic [19:0] s,
                                                    logic [9:0] l);
    return {t, b, o, s, l};
  endfunction

  function automatic vec_t mkv(logic st, logic rdy, logic [5:0] cfg, logic req,
                               logic [31:0] addr, logic [19:0] size, logic [1:0] typ,
                               logic bsy, logic dn, logic [5:0] ra);
    vec_t v;
    v.start = st; v.rdy = rdy; v.cfg = cfg; v.exp_req = req; v.exp_addr = addr;
    v.exp_size = size; v.exp_type = typ; v.exp_busy = bsy; v.exp_done = dn;
    v.exp_rom_addr = ra;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int i);
    @(negedge clk);
    start        = v.start;
    bus.rd_ready = v.rdy;
    cfg_last_idx = v.cfg;
    #1;
    n_vec++;
    if (bus.rd_req !== v.exp_req || bus.rd_addr !== v.exp_addr ||
        bus.rd_req_size !== v.exp_size || bus.rd_type !== v.exp_type ||
        busy !== v.exp_busy || done !== v.exp_done || bus.rom_addr !== v.exp_rom_addr) begin
      n_bad++;
      $display("FAIL vec%0d: got req=%b addr=%h size=%0d type=%0d busy=%b done=%b rom_addr=%0d expected req=%b addr=%h size=%0d type=%0d busy=%b done=%b rom_addr=%0d",
               i, bus.rd_req, bus.rd_addr, bus.rd_req_size, bus.rd_type, busy, done, bus.rom_addr,
               v.exp_req, v.exp_addr, v.exp_size, v.exp_type, v.exp_busy, v.exp_done, v.exp_rom_addr);
    end else begin
      $display("vec%0d: req=%b addr=%h busy=%b done=%b", i, bus.rd_req, bus.rd_addr, busy, done);
    end
  endtask

  // Pulse start, then record requests until done or the cycle budget runs out.
  task automatic run_walk(input int budget, output int nreq, output logic got_done);
    nreq     = 0;
    got_done = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (bus.rd_req) begin
        if (nreq < 16) addrs[nreq] = bus.rd_addr;
        $display("req %0d: addr=%h size=%0d", nreq, bus.rd_addr, bus.rd_req_size);
        nreq++;
      end
      if (done) begin
        got_done = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   nreq;
    int   cnt;
    logic got_done;

    for (int i = 0; i < 64; i++) rom_mem[i] = '0;
    rom_mem[0] = mk_entry(2'd2, 32'h0000_1000, 16'h0040, 20'd16, 10'd3);
    rom_mem[1] = mk_entry(2'd1, 32'h0000_2000, 16'h0010, 20'd8, 10'd0);

    //            st rdy cfg req addr          size typ bsy dn ra
    vecs[0]  = mkv(1, 1, 1, 0, 32'h0,         0,   0,  0,  0, 0);
    vecs[1]  = mkv(0, 1, 0, 0, 32'h0,         0,   0,  1,  0, 0);
    vecs[2]  = mkv(0, 1, 0, 0, 32'h0,         0,   0,  1,  0, 0);
    vecs[3]  = mkv(0, 1, 0, 1, 32'h0000_1000, 16,  2,  1,  0, 0);
    vecs[4]  = mkv(0, 1, 0, 1, 32'h0000_1040, 16,  2,  1,  0, 0);
    vecs[5]  = mkv(1, 0, 0, 0, 32'h0000_1080, 16,  2,  1,  0, 0);
    vecs[6]  = mkv(0, 0, 0, 0, 32'h0000_1080, 16,  2,  1,  0, 0);
    vecs[7]  = mkv(0, 1, 0, 1, 32'h0000_1080, 16,  2,  1,  0, 0);
    vecs[8]  = mkv(0, 1, 0, 1, 32'h0000_10C0, 16,  2,  1,  0, 0);
    vecs[9]  = mkv(0, 1, 0, 0, 32'h0,         0,   0,  1,  0, 1);
    vecs[10] = mkv(0, 1, 0, 0, 32'h0,         0,   0,  1,  0, 1);
    vecs[11] = mkv(0, 1, 0, 1, 32'h0000_2000, 8,   1,  1,  0, 1);
    vecs[12] = mkv(0, 1, 0, 0, 32'h0,         0,   0,  1,  1, 1);
    vecs[13] = mkv(0, 1, 0, 0, 32'h0,         0,   0,  0,  0, 1);
    vecs[14] = mkv(0, 1, 0, 0, 32'h0,         0,   0,  0,  0, 1);

    // Reset state, checked while reset is held low.
    bus.rd_ready = 1'b1;
    start        = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs",
          {bus.rd_req, done, busy, bus.rd_addr, bus.rd_req_size, bus.rd_type, bus.rom_addr},
          64'h0);
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;

    // Two-entry walk with ready stalls, a start while busy and a changing cfg_last_idx.
    for (int i = 0; i < 15; i++) apply(vecs[i], i);

    // Accumulator wraps past 2^32.
    rom_mem[0]   = mk_entry(2'd3, 32'hFFFF_FFC0, 16'h0040, 20'd4, 10'd1);
    cfg_last_idx = '0;
    bus.rd_ready = 1'b1;
    run_walk(20, nreq, got_done);
    check("wrap_nreq", 64'(nreq), 64'd2);
    check("wrap_addr0", 64'(addrs[0]), 64'hFFFF_FFC0);
    check("wrap_addr1", 64'(addrs[1]), 64'h0);
    check("wrap_done", 64'(got_done), 64'd1);

    // Reset right after the 2nd request of a loop_max=7 entry.
    rom_mem[0] = mk_entry(2'd0, 32'h0000_3000, 16'h0008, 20'd32, 10'd7);
    cnt = 0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (bus.rd_req) cnt++;
      if (cnt == 2) begin
        reset = 1'b0;
        break;
      end
    end
    check("midreset_reached_2nd_req", 64'(cnt), 64'd2);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      check("midreset_quiet_in_reset", {62'd0, bus.rd_req, busy}, 64'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      check("midreset_no_autorestart", {62'd0, bus.rd_req, busy}, 64'd0);
    end

    // Fresh start restarts at entry 0 with a cleared accumulator.
    run_walk(40, nreq, got_done);
    check("restart_nreq", 64'(nreq), 64'd8);
    check("restart_addr0", 64'(addrs[0]), 64'h3000);
    check("restart_addr7", 64'(addrs[7]), 64'h3038);
    check("restart_done", 64'(got_done), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_rd_req_gen.md
MEM_RD_REQ_GEN -- requirements
Module: mem_rd_req_gen

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, 32, read address width
- BASE_ADDR_W, 32, ROM base-address field width
- OFFSET_ADDR_W, 16, ROM stride field width
- TX_SIZE_WIDTH, 20, transfer size width
- RD_LOOP_W, 10, loop-max field width
- D_TYPE_W, 2, data-type field width
- ROM_ADDR_W, 6, config ROM address width
REQ-002 Ports SHALL be:
- clk, in, 1, single clock; all logic on the rising edge
- reset, in, 1, synchronous, active-low
- start, in, 1, single-cycle pulse that starts the ROM walk
- cfg_last_idx, in, ROM_ADDR_W, index of the last valid ROM entry
- rom_addr, out, ROM_ADDR_W, config ROM address
- rom_data, in, ROM_WIDTH, ROM entry; 1-cycle read latency
- rd_ready, in, 1, downstream can accept a request
- rd_req, out, 1, read request strobe
- rd_addr, out, ADDR_W, request address
- rd_req_size, out, TX_SIZE_WIDTH, request size
- rd_type, out, D_TYPE_W, request data type
- busy, out, 1, walk in progress
- done, out, 1, single-cycle completion pulse
REQ-003 ROM_WIDTH SHALL equal D_TYPE_W+BASE_ADDR_W+OFFSET_ADDR_W+TX_SIZE_WIDTH+RD_LOOP_W.
REQ-004 rom_data fields SHALL be packed MSB to LSB as {type, base, offset, size, loop_max}.

Function
REQ-005 The FSM SHALL have exactly five states: IDLE, FETCH, LOAD, REQ, DONE.
REQ-006 IDLE: when start=1, the FSM SHALL go to FETCH, clear the entry index to 0 and clear offset accumulator and loop count.
REQ-007 FETCH SHALL drive rom_addr=entry index and go to LOAD on the next cycle.
REQ-008 LOAD SHALL register all rom_data fields and go to REQ.
REQ-009 In REQ, rd_req SHALL equal rd_ready, combinationally (at most one request per cycle).
REQ-010 While in REQ, rd_addr SHALL be (base + offset accumulator) modulo 2^ADDR_W; offset is zero-extended.
REQ-011 While in REQ, rd_req_size and rd_type SHALL equal the registered entry fields.
REQ-012 Each accepted request (rd_req=1) SHALL update state as follows:
- if loop count < loop_max: loop count +1 and accumulator += offset
- otherwise: advance to the next entry
REQ-013 Advancing to the next entry SHALL clear loop count and accumulator, then:
- if entry index == cfg_last_idx: go to DONE
- otherwise: increment the index and go to FETCH
REQ-014 Each entry SHALL produce exactly loop_max+1 requests; loop_max=0 SHALL produce one request at base.
REQ-015 DONE SHALL assert done for one cycle, then return to IDLE.
REQ-016 busy SHALL be 1 in every state except IDLE.
REQ-017 start SHALL be ignored while busy=1.
REQ-018 With rd_ready held at 1, the first rd_req SHALL occur 3 cycles after the edge that samples start.
REQ-019 With rd_ready held at 1, consecutive requests within one entry SHALL occur back-to-back.
REQ-020 Each entry boundary SHALL add exactly 2 idle cycles (FETCH, LOAD).
REQ-021 When rd_ready=0, the FSM SHALL hold in REQ, and the counters and outputs other than rd_req SHALL stay stable.
REQ-022 The accumulator SHALL be ADDR_W wide and wrap silently.
REQ-023 cfg_last_idx SHALL be sampled only at start and held for the whole walk.

Reset
REQ-024 When reset=0 at a clock edge, the FSM SHALL go to IDLE.
REQ-025 Reset SHALL clear index, loop count, accumulator and all registered fields to 0.
REQ-026 During and after reset, rd_req, done and busy SHALL be 0, and rd_addr, rd_req_size, rd_type and rom_addr SHALL be 0.
REQ-027 Reset asserted mid-walk SHALL abort the walk with no further rd_req.
REQ-028 After reset, a new start SHALL be required to begin a walk.

Structure
REQ-029 The FSM state encoding and the ROM field offset constants SHALL live in a shared header included by the module.
REQ-030 The loop-count/accumulator logic SHALL be one sub-module, mem_rd_addr_stepper, with inputs clear, step, offset and outputs count, addr_offset.

Verification
REQ-031 Single entry, base=0x1000, offset=0x40, size=16, loop_max=3, rd_ready=1 -> requests at 0x1000, 0x1040, 0x1080, 0x10C0, each size 16, then done 1 cycle after the last request.
REQ-032 Two entries, cfg_last_idx=1, second entry base=0x2000, loop_max=0 -> 5 requests in total, with exactly 2 gap cycles before the 0x2000 request.
REQ-033 rd_ready toggled 1,0,0,1 during the walk -> no rd_req while rd_ready=0, rd_addr held, address sequence unchanged.
REQ-034 base=0xFFFFFFC0, offset=0x40, loop_max=1 -> requests at 0xFFFFFFC0 then 0x00000000.
REQ-035 reset=0 driven after the 2nd request of a loop_max=7 entry -> no further rd_req and busy=0; a fresh start restarts at entry 0.
REQ-036 start pulsed while busy -> ignored; the request count equals that of a single walk.
